q_sys_freq_meter: RTL
=====================

# q_sys_freq_meter

Parametrised multi-channel frequency meter on an Avalon-MM slave, the next generation of the single-word input-port block in q_sys. It synchronises NUM_CH asynchronous inputs and counts their rising edges over a programmable gate window of clk cycles. Per-channel results are latched at window end, and an optional interrupt is raised. It supports one-shot and continuous modes, saturation with sticky overflow flags, and keeps the existing 1-cycle registered read.

## Interface
- NUM_CH, 4: input channels, 1..8
- CNT_W, 32: edge-counter/result width, 8..32
- SYNC_STAGES, 2: synchroniser flops per input, ≥2
- clk in 1: system clock
- reset_n in 1: reset, asynchronous, active-low
- address in 4: word address
- write in 1: write strobe
- writedata in 32: write data
- readdata out 32: registered read data
- in_port in NUM_CH: asynchronous signals to measure
- irq out 1: done & IRQ_EN, level

## Operation
- Register map:
  - 0 CTRL (RW): b0 EN, b1 CONT, b2 IRQ_EN, b3 START (write-only strobe, reads 0).
  - 1 GATE (RW, 32b): window length in clk cycles.
  - 2 STATUS:
    - b0 DONE, W1C.
    - b1 BUSY, RO.
    - b[8+NUM_CH-1:8] OVF, W1C per bit.
  - 4..4+NUM_CH-1 RESULT[i] (RO, zero-extended).
  - Other addresses read 0; writes to them are ignored.
- Per channel: SYNC_STAGES flops, then a prev flop. edge = sync & ~prev. Counter +1 per edge, saturating at all-ones. Incrementing while saturated sets an internal ovf_pending flag.
- FSM IDLE/RUN:
  - IDLE→RUN on write CTRL with EN=1 and START=1 and GATE≠0. This clears edge counters and ovf_pending, and loads gate_cnt = GATE-1.
  - Same write with GATE=0 is ignored; stays IDLE.
  - RUN: gate_cnt decrements each cycle. At gate_cnt==0:
    - RESULT[i] ← counter[i] (including that cycle's edge).
    - DONE ← 1; OVF[i] |= ovf_pending[i].
    - If CONT, counters ← 0 and gate_cnt ← GATE-1 (current GATE), staying in RUN with no dead cycle. Else → IDLE.
  - RUN, write CTRL with EN=0: abort to IDLE. RESULT, DONE and OVF unchanged.
  - RUN, write CTRL with START=1 (EN=1): restart window. Counters cleared; RESULT kept.
- GATE written during RUN takes effect at next window start only.
- BUSY = (state==RUN).

## Timing
- Reset values: readdata 0, irq 0, all registers 0, state IDLE, sync/prev flops 0.
- Read latency 1: readdata in cycle t+1 reflects register values at cycle t. Reads have no side effects.
- Writes take effect at the clock edge of the write cycle.
- An in_port rising edge is counted SYNC_STAGES+1 clk cycles after capture. Max measurable frequency is clk/2.
- Window = exactly GATE clk cycles of edge detection. The first counted cycle is the one after the START write.
- DONE and RESULT update in the same cycle. irq is asserted the following cycle; it is registered from DONE & IRQ_EN.
- W1C of DONE/OVF in the same cycle as hardware set: set wins.
- Reset mid-window: immediate return to reset values; no partial result is latched.

## Structure
- Package q_sys_freq_meter_pkg:
  - register address constants (ADDR_CTRL/GATE/STATUS/RESULT0);
  - CTRL/STATUS bit positions;
  - state enum {IDLE, RUN}.
- Sub-module q_sys_freq_meter_ch (CNT_W, SYNC_STAGES):
  - synchroniser, edge detect, saturating counter, ovf_pending;
  - inputs clear/in;
  - outputs count/ovf_pending.
  - Instantiated NUM_CH times by generate.
- Top module holds the FSM, gate counter, register file, read mux and irq.

## Test plan
- Reset: after reset_n release, reads of all addresses return 0 and irq=0. BUSY becomes 1 only after START.
- One-shot: GATE=1000, ch0 toggles period 10 clk, ch1 period 4 clk, START. Required: RESULT0=100±1, RESULT1=250±1, DONE=1, BUSY=0, irq=1 with IRQ_EN.
- Continuous: CONT=1, GATE=100, ch0 period 2 clk. Required: RESULT0=50 every window; consecutive DONE sets 100 cycles apart. The total across 10 windows is 500, so no edges are lost.
- Saturation: CNT_W=8, GATE=1000, ch0 period 2 clk. Required: RESULT0=255 and OVF0=1. Writing STATUS 0x100 clears OVF0.
- Abort/restart: mid-window, write EN=0. Required: BUSY=0 next cycle, RESULT unchanged. START with GATE=0 keeps BUSY=0.
- Simultaneous: W1C DONE in the same cycle as window end. Required: DONE reads 1 afterwards.

Source files
------------

// File: rtl/q_sys_freq_meter_pkg.sv
// Shared register map, control/status bit positions and FSM state type
// for the multi-channel frequency meter.
package q_sys_freq_meter_pkg;

  localparam logic [3:0] ADDR_CTRL    = 4'd0;
  localparam logic [3:0] ADDR_GATE    = 4'd1;
  localparam logic [3:0] ADDR_STATUS  = 4'd2;
  localparam logic [3:0] ADDR_RESULT0 = 4'd4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CONT   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_START  = 3;

  localparam int STAT_DONE = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_OVF  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/q_sys_freq_meter_ch.sv
// One measurement channel: input synchroniser, rising-edge detect and a
// saturating edge counter with a pending-overflow flag.
module q_sys_freq_meter_ch #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in,
  output logic [CNT_W-1:0] count,
  output logic             ovf_pending
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   edge_det;
  logic                   sat;

  // count/ovf_pending already include this cycle's edge so the window-end
  // latch in the parent sees the full window.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], in};
    prev_d      = sync_q[SYNC_STAGES-1];
    edge_det    = sync_q[SYNC_STAGES-1] & ~prev_q;
    sat         = &cnt_q;
    count       = (edge_det && !sat) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_pending = ovf_q | (edge_det & sat);
    cnt_d       = clear ? '0 : count;
    ovf_d       = clear ? 1'b0 : ovf_pending;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: rtl/q_sys_freq_meter.sv
// Multi-channel frequency meter on an Avalon-MM slave: gate-window FSM,
// register file, 1-cycle registered read and level interrupt.
module q_sys_freq_meter
  import q_sys_freq_meter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        address,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [NUM_CH-1:0] in_port,
  output logic              irq
);

  state_t             state_q, state_d;
  logic [31:0]        gate_cnt_q, gate_cnt_d;
  logic [31:0]        gate_q, gate_d;
  logic               en_q, en_d;
  logic               cont_q, cont_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic [NUM_CH-1:0]  ovf_q, ovf_d;
  logic [CNT_W-1:0]   result_q [NUM_CH];
  logic [CNT_W-1:0]   result_d [NUM_CH];
  logic [31:0]        readdata_q, readdata_d;
  logic               irq_q, irq_d;

  logic [CNT_W-1:0]   ch_count [NUM_CH];
  logic [NUM_CH-1:0]  ch_ovf;
  logic               ch_clear;
  logic               wr_ctrl, wr_gate, wr_status;
  logic               start_ok, abort, win_end;
  logic               done_set;
  logic [NUM_CH-1:0]  ovf_set;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    q_sys_freq_meter_ch #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (ch_clear),
      .in         (in_port[g]),
      .count      (ch_count[g]),
      .ovf_pending(ch_ovf[g])
    );
  end

  always_comb begin
    wr_ctrl   = write && (address == ADDR_CTRL);
    wr_gate   = write && (address == ADDR_GATE);
    wr_status = write && (address == ADDR_STATUS);
    start_ok  = wr_ctrl && writedata[CTRL_EN] && writedata[CTRL_START] && (gate_q != '0);
    abort     = wr_ctrl && (state_q == RUN) && !writedata[CTRL_EN];
    win_end   = (state_q == RUN) && (gate_cnt_q == '0);

    state_d    = state_q;
    gate_cnt_d = (state_q == RUN) ? gate_cnt_q - 32'd1 : gate_cnt_q;
    result_d   = result_q;
    done_set   = 1'b0;
    ovf_set    = '0;
    ch_clear   = 1'b0;

    // Start/restart and abort take priority over a coincident window end.
    if (start_ok) begin
      state_d    = RUN;
      gate_cnt_d = gate_q - 32'd1;
      ch_clear   = 1'b1;
    end else if (abort) begin
      state_d = IDLE;
    end else if (win_end) begin
      result_d = ch_count;
      done_set = 1'b1;
      ovf_set  = ch_ovf;
      if (cont_q && (gate_q != '0)) begin
        gate_cnt_d = gate_q - 32'd1;
        ch_clear   = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end

    en_d     = en_q;
    cont_d   = cont_q;
    irq_en_d = irq_en_q;
    if (wr_ctrl) begin
      en_d     = writedata[CTRL_EN];
      cont_d   = writedata[CTRL_CONT];
      irq_en_d = writedata[CTRL_IRQ_EN];
    end
    gate_d = wr_gate ? writedata : gate_q;

    // Hardware set beats a coincident write-1-to-clear.
    done_d = (done_q & ~(wr_status & writedata[STAT_DONE])) | done_set;
    ovf_d  = (ovf_q & ~({NUM_CH{wr_status}} & writedata[STAT_OVF +: NUM_CH])) | ovf_set;

    irq_d = done_q & irq_en_q;

    readdata_d = '0;
    case (address)
      ADDR_CTRL: begin
        readdata_d[CTRL_EN]     = en_q;
        readdata_d[CTRL_CONT]   = cont_q;
        readdata_d[CTRL_IRQ_EN] = irq_en_q;
      end
      ADDR_GATE: readdata_d = gate_q;
      ADDR_STATUS: begin
        readdata_d[STAT_DONE]           = done_q;
        readdata_d[STAT_BUSY]           = (state_q == RUN);
        readdata_d[STAT_OVF +: NUM_CH]  = ovf_q;
      end
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (address == ADDR_RESULT0 + 4'(i)) readdata_d = 32'(result_q[i]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      gate_q     <= '0;
      en_q       <= 1'b0;
      cont_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= '0;
      result_q   <= '{default: '0};
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      gate_q     <= gate_d;
      en_q       <= en_d;
      cont_q     <= cont_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
